// File: rtl/bank64k_arbiter.sv
// Access initiator for one 64-bit x 1024 data bank.
// Round-robin read and write arbitration across three clients (i, d, c),
// with a tag pipeline that returns read-valid strobes to the client that
// issued each read, RD_LAT cycles after its grant.
module bank64k_arbiter #(
  parameter int A          = 10,
  parameter int RD_LAT     = 1,   // 1 or 2
  parameter int ADDR_GUARD = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_rd_req,
  input  logic         d_rd_req,
  input  logic         c_rd_req,
  input  logic [A-1:0] i_rd_addr,
  input  logic [A-1:0] d_rd_addr,
  input  logic [A-1:0] c_rd_addr,
  output logic         i_rd_gnt,
  output logic         d_rd_gnt,
  output logic         c_rd_gnt,
  output logic         i_rd_vld,
  output logic         d_rd_vld,
  output logic         c_rd_vld,
  input  logic         i_wr_req,
  input  logic         d_wr_req,
  input  logic         c_wr_req,
  input  logic [A-1:0] i_wr_addr,
  input  logic [A-1:0] d_wr_addr,
  input  logic [A-1:0] c_wr_addr,
  output logic         i_wr_gnt,
  output logic         d_wr_gnt,
  output logic         c_wr_gnt,
  output logic         bank_rd_en,
  output logic [A-1:0] bank_rd_addr,
  output logic [1:0]   bank_rd_muxcode,
  output logic         bank_wr_en,
  output logic [A-1:0] bank_wr_addr,
  output logic [1:0]   bank_wr_muxcode
);

  localparam logic [1:0] IDLE_CODE = 2'b11;

  // (ptr + k) mod 3 for ptr, k in 0..2
  function automatic logic [1:0] wrap3(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Select one of three addresses by source code
  function automatic logic [A-1:0] sel3(input logic [1:0] s, input logic [A-1:0] a0,
                                        input logic [A-1:0] a1, input logic [A-1:0] a2);
    case (s)
      2'd0:    return a0;
      2'd1:    return a1;
      default: return a2;
    endcase
  endfunction

  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [3:0]   wr_req_pad, rd_elig_pad;
  logic [2:0]   rd_req_v, rd_elig, wr_gnt_v, rd_gnt_v;
  logic [A-1:0] rd_addr_v [3];
  logic         wr_found, rd_found;
  logic [1:0]   wr_win, rd_win;
  logic         tag_vld_q  [RD_LAT];
  logic [1:0]   tag_code_q [RD_LAT];

  assign rd_req_v     = {c_rd_req, d_rd_req, i_rd_req};
  assign rd_addr_v[0] = i_rd_addr;
  assign rd_addr_v[1] = d_rd_addr;
  assign rd_addr_v[2] = c_rd_addr;
  assign wr_req_pad   = {1'b0, c_wr_req, d_wr_req, i_wr_req};

  // Write round robin: lowest offset from wr_ptr among requesters wins
  always_comb begin
    wr_found = 1'b0;
    wr_win   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (wr_req_pad[wrap3(wr_ptr_q, 2'(k))]) begin
        wr_found = 1'b1;
        wr_win   = wrap3(wr_ptr_q, 2'(k));
      end
    end
  end

  assign bank_wr_en      = rst_n & wr_found;
  assign wr_gnt_v        = bank_wr_en ? (3'b001 << wr_win) : 3'b000;
  assign bank_wr_addr    = bank_wr_en ? sel3(wr_win, i_wr_addr, d_wr_addr, c_wr_addr) : '0;
  assign bank_wr_muxcode = bank_wr_en ? wr_win : IDLE_CODE;
  assign i_wr_gnt        = wr_gnt_v[0];
  assign d_wr_gnt        = wr_gnt_v[1];
  assign c_wr_gnt        = wr_gnt_v[2];

  // A read colliding with this cycle's granted write address is held off
  // so it observes the committed data on a later cycle.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_elig
      assign rd_elig[gi] = rd_req_v[gi] &
                           ~((ADDR_GUARD != 0) && bank_wr_en && (rd_addr_v[gi] == bank_wr_addr));
    end
  endgenerate
  assign rd_elig_pad = {1'b0, rd_elig};

  // Read round robin over eligible clients, independent pointer
  always_comb begin
    rd_found = 1'b0;
    rd_win   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (rd_elig_pad[wrap3(rd_ptr_q, 2'(k))]) begin
        rd_found = 1'b1;
        rd_win   = wrap3(rd_ptr_q, 2'(k));
      end
    end
  end

  assign bank_rd_en      = rst_n & rd_found;
  assign rd_gnt_v        = bank_rd_en ? (3'b001 << rd_win) : 3'b000;
  assign bank_rd_addr    = bank_rd_en ? sel3(rd_win, i_rd_addr, d_rd_addr, c_rd_addr) : '0;
  assign bank_rd_muxcode = bank_rd_en ? rd_win : IDLE_CODE;
  assign i_rd_gnt        = rd_gnt_v[0];
  assign d_rd_gnt        = rd_gnt_v[1];
  assign c_rd_gnt        = rd_gnt_v[2];

  // Pointers advance just past the actual winner, hold otherwise
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bank_wr_en) wr_ptr_d = (wr_win == 2'd2) ? 2'd0 : wr_win + 2'd1;
    if (bank_rd_en) rd_ptr_d = (rd_win == 2'd2) ? 2'd0 : rd_win + 2'd1;
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Read tag pipeline; reset drops in-flight tags so no stale valid fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tag_vld_q[s]  <= 1'b0;
        tag_code_q[s] <= IDLE_CODE;
      end
    end else begin
      tag_vld_q[0]  <= bank_rd_en;
      tag_code_q[0] <= bank_rd_muxcode;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld_q[s]  <= tag_vld_q[s-1];
        tag_code_q[s] <= tag_code_q[s-1];
      end
    end
  end

  assign i_rd_vld = tag_vld_q[RD_LAT-1] && (tag_code_q[RD_LAT-1] == 2'b00);
  assign d_rd_vld = tag_vld_q[RD_LAT-1] && (tag_code_q[RD_LAT-1] == 2'b01);
  assign c_rd_vld = tag_vld_q[RD_LAT-1] && (tag_code_q[RD_LAT-1] == 2'b10);

endmodule

// File: tb/tb_bank64k_arbiter.sv
// Bench for bank64k_arbiter: two instances share stimulus.
// dut_a: RD_LAT=1, ADDR_GUARD=1.  dut_b: RD_LAT=2, ADDR_GUARD=0.
module tb_bank64k_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rd_req, wr_req;       // bit0=i, bit1=d, bit2=c
  logic [9:0] ra_i, ra_d, ra_c;
  logic [9:0] wa_i, wa_d, wa_c;

  wire [2:0] a_rg, a_wg, a_vld, b_rg, b_wg, b_vld;
  wire       a_ren, a_wen, b_ren, b_wen;
  wire [9:0] a_raddr, a_waddr, b_raddr, b_waddr;
  wire [1:0] a_rmux, a_wmux, b_rmux, b_wmux;

  bank64k_arbiter #(.A(10), .RD_LAT(1), .ADDR_GUARD(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_rd_req(rd_req[0]), .d_rd_req(rd_req[1]), .c_rd_req(rd_req[2]),
    .i_rd_addr(ra_i), .d_rd_addr(ra_d), .c_rd_addr(ra_c),
    .i_rd_gnt(a_rg[0]), .d_rd_gnt(a_rg[1]), .c_rd_gnt(a_rg[2]),
    .i_rd_vld(a_vld[0]), .d_rd_vld(a_vld[1]), .c_rd_vld(a_vld[2]),
    .i_wr_req(wr_req[0]), .d_wr_req(wr_req[1]), .c_wr_req(wr_req[2]),
    .i_wr_addr(wa_i), .d_wr_addr(wa_d), .c_wr_addr(wa_c),
    .i_wr_gnt(a_wg[0]), .d_wr_gnt(a_wg[1]), .c_wr_gnt(a_wg[2]),
    .bank_rd_en(a_ren), .bank_rd_addr(a_raddr), .bank_rd_muxcode(a_rmux),
    .bank_wr_en(a_wen), .bank_wr_addr(a_waddr), .bank_wr_muxcode(a_wmux)
  );

  bank64k_arbiter #(.A(10), .RD_LAT(2), .ADDR_GUARD(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_rd_req(rd_req[0]), .d_rd_req(rd_req[1]), .c_rd_req(rd_req[2]),
    .i_rd_addr(ra_i), .d_rd_addr(ra_d), .c_rd_addr(ra_c),
    .i_rd_gnt(b_rg[0]), .d_rd_gnt(b_rg[1]), .c_rd_gnt(b_rg[2]),
    .i_rd_vld(b_vld[0]), .d_rd_vld(b_vld[1]), .c_rd_vld(b_vld[2]),
    .i_wr_req(wr_req[0]), .d_wr_req(wr_req[1]), .c_wr_req(wr_req[2]),
    .i_wr_addr(wa_i), .d_wr_addr(wa_d), .c_wr_addr(wa_c),
    .i_wr_gnt(b_wg[0]), .d_wr_gnt(b_wg[1]), .c_wr_gnt(b_wg[2]),
    .bank_rd_en(b_ren), .bank_rd_addr(b_raddr), .bank_rd_muxcode(b_rmux),
    .bank_wr_en(b_wen), .bank_wr_addr(b_waddr), .bank_wr_muxcode(b_wmux)
  );

  typedef struct {
    logic [2:0] rdq, wrq;
    logic [9:0] ri, rd, rc;
    logic [2:0] e_rg, e_wg;
    logic [9:0] e_raddr;
    logic [1:0] e_rmux;
    logic [9:0] e_waddr;
    logic [1:0] e_wmux;
    logic [2:0] e_avld, e_bg, e_bvld;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(logic [2:0] rdq, logic [2:0] wrq,
                              logic [9:0] ri, logic [9:0] rd, logic [9:0] rc,
                              logic [2:0] e_rg, logic [2:0] e_wg,
                              logic [9:0] e_raddr, logic [1:0] e_rmux,
                              logic [9:0] e_waddr, logic [1:0] e_wmux,
                              logic [2:0] e_avld, logic [2:0] e_bg, logic [2:0] e_bvld);
    vec_t v;
    v.rdq = rdq; v.wrq = wrq; v.ri = ri; v.rd = rd; v.rc = rc;
    v.e_rg = e_rg; v.e_wg = e_wg; v.e_raddr = e_raddr; v.e_rmux = e_rmux;
    v.e_waddr = e_waddr; v.e_wmux = e_wmux;
    v.e_avld = e_avld; v.e_bg = e_bg; v.e_bvld = e_bvld;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(logic [2:0] rdq, logic [2:0] wrq,
                       logic [9:0] ri, logic [9:0] rd, logic [9:0] rc);
    rd_req = rdq; wr_req = wrq; ra_i = ri; ra_d = rd; ra_c = rc;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wa_i = 10'h100; wa_d = 10'h010; wa_c = 10'h102;

    //   rdq    wrq    ri      rd      rc      rg     wg     raddr   rm     waddr   wm     avld   bg     bvld
    add(3'b001,3'b000,10'h005,10'h000,10'h000,3'b001,3'b000,10'h005,2'd0, 10'h000,2'd3, 3'b000,3'b001,3'b000); // 0 single read i
    add(3'b000,3'b000,10'h000,10'h000,10'h000,3'b000,3'b000,10'h000,2'd3, 10'h000,2'd3, 3'b001,3'b000,3'b000); // 1
    add(3'b000,3'b000,10'h000,10'h000,10'h000,3'b000,3'b000,10'h000,2'd3, 10'h000,2'd3, 3'b000,3'b000,3'b001); // 2
    add(3'b000,3'b111,10'h000,10'h000,10'h000,3'b000,3'b001,10'h000,2'd3, 10'h100,2'd0, 3'b000,3'b000,3'b000); // 3 write RR
    add(3'b000,3'b111,10'h000,10'h000,10'h000,3'b000,3'b010,10'h000,2'd3, 10'h010,2'd1, 3'b000,3'b000,3'b000); // 4
    add(3'b000,3'b111,10'h000,10'h000,10'h000,3'b000,3'b100,10'h000,2'd3, 10'h102,2'd2, 3'b000,3'b000,3'b000); // 5
    add(3'b000,3'b111,10'h000,10'h000,10'h000,3'b000,3'b001,10'h000,2'd3, 10'h100,2'd0, 3'b000,3'b000,3'b000); // 6
    add(3'b000,3'b111,10'h000,10'h000,10'h000,3'b000,3'b010,10'h000,2'd3, 10'h010,2'd1, 3'b000,3'b000,3'b000); // 7
    add(3'b000,3'b111,10'h000,10'h000,10'h000,3'b000,3'b100,10'h000,2'd3, 10'h102,2'd2, 3'b000,3'b000,3'b000); // 8
    add(3'b010,3'b000,10'h000,10'h030,10'h000,3'b010,3'b000,10'h030,2'd1, 10'h000,2'd3, 3'b000,3'b010,3'b000); // 9 rd_ptr -> c
    add(3'b101,3'b010,10'h020,10'h000,10'h010,3'b001,3'b010,10'h020,2'd0, 10'h010,2'd1, 3'b010,3'b100,3'b000); // 10 address guard
    add(3'b100,3'b000,10'h000,10'h000,10'h010,3'b100,3'b000,10'h010,2'd2, 10'h000,2'd3, 3'b001,3'b100,3'b010); // 11 c retried
    add(3'b000,3'b000,10'h000,10'h000,10'h000,3'b000,3'b000,10'h000,2'd3, 10'h000,2'd3, 3'b100,3'b000,3'b100); // 12
    add(3'b000,3'b000,10'h000,10'h000,10'h000,3'b000,3'b000,10'h000,2'd3, 10'h000,2'd3, 3'b000,3'b000,3'b100); // 13
    add(3'b010,3'b000,10'h000,10'h040,10'h000,3'b010,3'b000,10'h040,2'd1, 10'h000,2'd3, 3'b000,3'b010,3'b000); // 14 d,c,idle,i
    add(3'b100,3'b000,10'h000,10'h000,10'h050,3'b100,3'b000,10'h050,2'd2, 10'h000,2'd3, 3'b010,3'b100,3'b000); // 15
    add(3'b000,3'b000,10'h000,10'h000,10'h000,3'b000,3'b000,10'h000,2'd3, 10'h000,2'd3, 3'b100,3'b000,3'b010); // 16
    add(3'b001,3'b000,10'h060,10'h000,10'h000,3'b001,3'b000,10'h060,2'd0, 10'h000,2'd3, 3'b000,3'b001,3'b100); // 17
    add(3'b000,3'b000,10'h000,10'h000,10'h000,3'b000,3'b000,10'h000,2'd3, 10'h000,2'd3, 3'b001,3'b000,3'b000); // 18
    add(3'b000,3'b000,10'h000,10'h000,10'h000,3'b000,3'b000,10'h000,2'd3, 10'h000,2'd3, 3'b000,3'b000,3'b001); // 19
    add(3'b111,3'b000,10'h001,10'h002,10'h003,3'b010,3'b000,10'h002,2'd1, 10'h000,2'd3, 3'b000,3'b010,3'b000); // 20 read RR
    add(3'b111,3'b000,10'h001,10'h002,10'h003,3'b100,3'b000,10'h003,2'd2, 10'h000,2'd3, 3'b010,3'b100,3'b000); // 21
    add(3'b111,3'b000,10'h001,10'h002,10'h003,3'b001,3'b000,10'h001,2'd0, 10'h000,2'd3, 3'b100,3'b001,3'b010); // 22
    add(3'b000,3'b000,10'h000,10'h000,10'h000,3'b000,3'b000,10'h000,2'd3, 10'h000,2'd3, 3'b001,3'b000,3'b100); // 23

    // Reset state: requests high while rst_n is low must still yield nothing
    drive(3'b111, 3'b111, 10'h3ff, 10'h3ff, 10'h3ff);
    cyc(); cyc();
    #2;
    chk("rst_a_rd_gnt", -1, {29'd0, a_rg}, 32'd0);
    chk("rst_a_wr_gnt", -1, {29'd0, a_wg}, 32'd0);
    chk("rst_a_en", -1, {30'd0, a_ren, a_wen}, 32'd0);
    chk("rst_a_addr", -1, {12'd0, a_raddr, a_waddr}, 32'd0);
    chk("rst_a_mux", -1, {28'd0, a_rmux, a_wmux}, 32'hf);
    chk("rst_vld", -1, {26'd0, a_vld, b_vld}, 32'd0);
    drive(3'b000, 3'b000, 10'h000, 10'h000, 10'h000);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Table-driven vectors, one cycle each
    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].rdq, vecs[n].wrq, vecs[n].ri, vecs[n].rd, vecs[n].rc);
      #2;
      chk("a_rd_gnt", n, {29'd0, a_rg}, {29'd0, vecs[n].e_rg});
      chk("a_wr_gnt", n, {29'd0, a_wg}, {29'd0, vecs[n].e_wg});
      chk("a_rd_en",  n, {31'd0, a_ren}, {31'd0, |vecs[n].e_rg});
      chk("a_wr_en",  n, {31'd0, a_wen}, {31'd0, |vecs[n].e_wg});
      chk("a_rd_mux", n, {30'd0, a_rmux}, {30'd0, vecs[n].e_rmux});
      chk("a_wr_mux", n, {30'd0, a_wmux}, {30'd0, vecs[n].e_wmux});
      if (|vecs[n].e_rg) chk("a_rd_addr", n, {22'd0, a_raddr}, {22'd0, vecs[n].e_raddr});
      if (|vecs[n].e_wg) chk("a_wr_addr", n, {22'd0, a_waddr}, {22'd0, vecs[n].e_waddr});
      chk("a_rd_vld", n, {29'd0, a_vld}, {29'd0, vecs[n].e_avld});
      chk("b_rd_gnt", n, {29'd0, b_rg}, {29'd0, vecs[n].e_bg});
      chk("b_rd_vld", n, {29'd0, b_vld}, {29'd0, vecs[n].e_bvld});
      $display("step %0d rdq=%b wrq=%b a_rg=%b a_wg=%b a_vld=%b b_rg=%b b_vld=%b",
               n, vecs[n].rdq, vecs[n].wrq, a_rg, a_wg, a_vld, b_rg, b_vld);
      cyc();
    end

    // Reset mid-flight: c read granted, reset pulsed next cycle, no valid may follow
    drive(3'b100, 3'b000, 10'h000, 10'h000, 10'h077);
    #2;
    chk("mid_b_c_gnt", 100, {29'd0, b_rg}, 32'b100);
    cyc();
    rst_n = 1'b0;
    drive(3'b111, 3'b111, 10'h001, 10'h002, 10'h003);
    #2;
    chk("mid_rst_gnt", 101, {26'd0, a_rg, b_rg}, 32'd0);
    chk("mid_rst_vld", 101, {26'd0, a_vld, b_vld}, 32'd0);
    chk("mid_rst_mux", 101, {28'd0, b_rmux, b_wmux}, 32'hf);
    drive(3'b000, 3'b000, 10'h000, 10'h000, 10'h000);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #2;
      chk("post_rst_b_vld", 102 + k, {29'd0, b_vld}, 32'd0);
      $display("post-reset cycle %0d b_vld=%b", k, b_vld);
    end

    // Pointers back at i: all clients request read and write
    drive(3'b111, 3'b111, 10'h001, 10'h002, 10'h003);
    #2;
    chk("post_rst_a_rd", 110, {29'd0, a_rg}, 32'b001);
    chk("post_rst_a_wr", 110, {29'd0, a_wg}, 32'b001);
    chk("post_rst_b_rd", 110, {29'd0, b_rg}, 32'b001);
    chk("post_rst_a_wmux", 110, {30'd0, a_wmux}, 32'd0);
    $display("post-reset all-request a_rg=%b a_wg=%b b_rg=%b", a_rg, a_wg, b_rg);
    cyc();
    drive(3'b000, 3'b000, 10'h000, 10'h000, 10'h000);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
